// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for the multicycle CPU datapath. It sequences one
//   instruction through fetch, decode, address/execute, memory and writeback.
//   Outputs are decoded from the current state (Moore). The exceptions are
//   pc_en, the mem_ready-gated IR/PC writes in FETCH, and illegal_op.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   op[5:0]           opcode from the instruction register
//   zero              ALU zero flag
//   mem_ready         memory completes the current access this cycle
//   alu_op[1:0]       00 add, 01 sub, 10 use funct (to alu_decoder)
//   alu_src_a         0 PC, 1 reg A
//   alu_src_b[1:0]    00 reg B, 01 const 4, 10 sext imm, 11 imm<<2
//   pc_src[1:0]       00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d            memory address: 0 PC, 1 ALUOut
//   ir_write, mem_write, reg_write, reg_dst, mem_to_reg, branch, pc_write
//   pc_en             pc_write | (branch & zero)
//   illegal_op        one-cycle pulse on an unsupported opcode in DECODE
//   state[3:0]        current state code (debug)
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       branch,
  output logic       pc_write,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t r_state;
  state_t w_next;
  state_t w_dec_state;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // While reset is held, decode as FETCH so a half-finished instruction
  // cannot issue any further write enables.
  assign w_dec_state = reset ? S_FETCH : r_state;

  always_comb begin
    w_next     = S_FETCH;
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    pc_write   = 1'b0;
    illegal_op = 1'b0;
    case (w_dec_state)
      S_FETCH: begin
        alu_src_b = 2'b01;
        // IR and PC latch only on the cycle the instruction word arrives.
        ir_write  = mem_ready & ~reset;
        pc_write  = mem_ready & ~reset;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next     = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // IR is not written here, so op still holds the lw/sw opcode.
        w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        i_or_d = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        w_next    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: begin
        // Codes 12-15: all outputs stay 0, recover to FETCH.
        w_next = S_FETCH;
      end
    endcase
  end

  assign pc_en = pc_write | (branch & zero);
  assign state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
  logic       branch, pc_write, pc_en, illegal_op;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .i_or_d(i_or_d), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .branch(branch), .pc_write(pc_write),
    .pc_en(pc_en), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic       iod, irw, mw, rw, rd, m2r, br, pw, pen, ill;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } vec_t;

  //                                  st     aop   sa    sb    ps    iod  irw  mw   rw   rd   m2r  br   pw   pen  ill
  localparam out_t F_W   = '{4'd0,  2'd0, 1'b0, 2'd1, 2'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam out_t F_S   = '{4'd0,  2'd0, 1'b0, 2'd1, 2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t DEC   = '{4'd1,  2'd0, 1'b0, 2'd3, 2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t DILL  = '{4'd1,  2'd0, 1'b0, 2'd3, 2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
  localparam out_t MA    = '{4'd2,  2'd0, 1'b1, 2'd2, 2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t MR    = '{4'd3,  2'd0, 1'b0, 2'd0, 2'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t MWB   = '{4'd4,  2'd0, 1'b0, 2'd0, 2'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
  localparam out_t MWR   = '{4'd5,  2'd0, 1'b0, 2'd0, 2'd0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t EX    = '{4'd6,  2'd2, 1'b1, 2'd0, 2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t AWB   = '{4'd7,  2'd0, 1'b0, 2'd0, 2'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t BR_Z  = '{4'd8,  2'd1, 1'b1, 2'd0, 2'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
  localparam out_t BR_N  = '{4'd8,  2'd1, 1'b1, 2'd0, 2'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
  localparam out_t AEX   = '{4'd9,  2'd0, 1'b1, 2'd2, 2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t AIWB  = '{4'd10, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t JMP   = '{4'd11, 2'd0, 1'b0, 2'd0, 2'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  // Reset held while sitting in EXECUTE / MEMRD: state still shows the old
  // code, outputs are the FETCH decode with no write enables.
  localparam out_t RST_EX = '{4'd6, 2'd0, 1'b0, 2'd1, 2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam out_t RST_MR = '{4'd3, 2'd0, 1'b0, 2'd1, 2'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input string n, input logic r, input logic [5:0] o,
                     input logic z, input logic rd, input out_t e);
    vec_t v;
    v.name = n; v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic out_t actual();
    out_t a;
    a = '{state, alu_op, alu_src_a, alu_src_b, pc_src, i_or_d, ir_write,
          mem_write, reg_write, reg_dst, mem_to_reg, branch, pc_write, pc_en,
          illegal_op};
    return a;
  endfunction

  task automatic check(input string n, input out_t e);
    out_t a;
    a = actual();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic check_int(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  initial begin
    int mw_cnt, rw_cnt, k;

    // reset state and fetch stall
    add("rst_hold",   1, RT,  0, 1, F_S);
    add("fetch_stall",0, RT,  0, 0, F_S);
    // R-type
    add("rt_fetch",   0, RT,  0, 1, F_W);
    add("rt_decode",  0, RT,  0, 1, DEC);
    add("rt_exec",    0, RT,  0, 1, EX);
    add("rt_aluwb",   0, RT,  0, 1, AWB);
    // lw with two MEMRD stall cycles
    add("lw_fetch",   0, LW,  0, 1, F_W);
    add("lw_decode",  0, LW,  0, 1, DEC);
    add("lw_memadr",  0, LW,  0, 1, MA);
    add("lw_memrd0",  0, LW,  0, 0, MR);
    add("lw_memrd1",  0, LW,  0, 0, MR);
    add("lw_memrd2",  0, LW,  0, 1, MR);
    add("lw_memwb",   0, LW,  0, 1, MWB);
    // sw with one MEMWR stall cycle
    add("sw_fetch",   0, SW,  0, 1, F_W);
    add("sw_decode",  0, SW,  0, 1, DEC);
    add("sw_memadr",  0, SW,  0, 1, MA);
    add("sw_memwr0",  0, SW,  0, 0, MWR);
    add("sw_memwr1",  0, SW,  0, 1, MWR);
    // beq taken / not taken
    add("beq_fetch",  0, BEQ, 1, 1, F_W);
    add("beq_decode", 0, BEQ, 1, 1, DEC);
    add("beq_zero1",  0, BEQ, 1, 1, BR_Z);
    add("beq2_fetch", 0, BEQ, 0, 1, F_W);
    add("beq2_decode",0, BEQ, 0, 1, DEC);
    add("beq_zero0",  0, BEQ, 0, 1, BR_N);
    // j then addi
    add("j_fetch",    0, J,   0, 1, F_W);
    add("j_decode",   0, J,   0, 1, DEC);
    add("j_jump",     0, J,   0, 1, JMP);
    add("ai_fetch",   0, ADDI,0, 1, F_W);
    add("ai_decode",  0, ADDI,0, 1, DEC);
    add("ai_ex",      0, ADDI,0, 1, AEX);
    add("ai_wb",      0, ADDI,0, 1, AIWB);
    // illegal opcode
    add("ill_fetch",  0, BAD, 0, 1, F_W);
    add("ill_decode", 0, BAD, 0, 1, DILL);
    // reset in EXECUTE: ALUWB must never be entered
    add("rex_fetch",  0, RT,  0, 1, F_W);
    add("rex_decode", 0, RT,  0, 1, DEC);
    add("rex_exec",   1, RT,  0, 1, RST_EX);
    add("rex_after",  0, RT,  0, 1, F_W);
    // reset during a MEMRD stall
    add("rmr_decode", 0, LW,  0, 1, DEC);
    add("rmr_memadr", 0, LW,  0, 1, MA);
    add("rmr_stall",  1, LW,  0, 0, RST_MR);
    add("rmr_after",  0, LW,  0, 0, F_S);

    reset = 1'b1; op = RT; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; op = vecs[i].op;
      zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      #1;
      check(vecs[i].name, vecs[i].exp);
    end

    // Hand sequence: sw with a 1-cycle MEMWR stall, count write strobes
    // over the whole instruction.
    @(negedge clk);
    reset = 1'b1; op = SW; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mw_cnt = 0; rw_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      // stall exactly the first MEMWR cycle
      mem_ready = !(state == 4'd5 && mw_cnt == 0);
      #1;
      if (mem_write) mw_cnt++;
      if (reg_write) rw_cnt++;
      @(negedge clk);
      if (state == 4'd0 && c > 1) break;
    end
    check_int("sw_memwrite_cycles", mw_cnt, 2);
    check_int("sw_regwrite_cycles", rw_cnt, 0);

    // Hand sequence: illegal opcode issues no write enables and returns to
    // FETCH within a bounded number of cycles.
    op = BAD; mem_ready = 1'b1;
    rw_cnt = 0; mw_cnt = 0; k = 0;
    while (state != 4'd1 && k < 10) begin
      @(negedge clk); k++;
    end
    check_int("ill_reach_decode", int'(state), 1);
    #1;
    if (reg_write || mem_write || ir_write || pc_write) rw_cnt++;
    check_int("ill_pulse", int'(illegal_op), 1);
    @(negedge clk); #1;
    check_int("ill_next_state", int'(state), 0);
    check_int("ill_pulse_gone", int'(illegal_op), 0);
    check_int("ill_no_writes", rw_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle CPU datapath. It sequences one instruction over several cycles: fetch, decode, address/execute, memory, writeback. Each cycle it drives the mux selects, register/memory write enables and the 2-bit ALU operation class consumed by `alu_decoder`. It sits beside `alu_decoder` in the control unit and takes the opcode from the instruction register and the ALU zero flag from the datapath.

## Interface
- No parameters. Encodings are fixed by the ISA.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `op`  in  6  opcode field, instr[31:26], from the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `alu_op`  out  2  to `alu_decoder`: 00 add, 01 subtract, 10 use funct.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `ir_write`, `mem_write`, `reg_write`, `reg_dst`, `mem_to_reg`, `branch`, `pc_write`  out  1 each  datapath controls.
- `pc_en`  out  1  `pc_write | (branch & zero)`, combinational.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `state`  out  4  current state code, for debug.

## Operation
- Moore FSM on a 4-bit state register. Outputs decode from the state only, except:
  - `pc_en`, which combines `branch` with `zero`;
  - the `mem_ready` gating listed below;
  - `illegal_op`.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
  - Codes 12–15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- Every output is 0 unless listed for the state:
  - FETCH: alu_src_b=01; ir_write = pc_write = mem_ready. Holds in FETCH while !mem_ready, else goes to DECODE.
  - DECODE: alu_src_b=11. Next state by `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXECUTE
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - any other opcode → FETCH with illegal_op=1 for this cycle.
  - MEMADR: alu_src_a=1, alu_src_b=10. Goes to MEMRD for lw, MEMWR for sw. `op` is re-sampled here and is stable because the IR is not written.
  - MEMRD: i_or_d=1. Holds while !mem_ready, else goes to MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1 (reg_dst=0). Then FETCH.
  - MEMWR: i_or_d=1, mem_write=1 held for the whole stall. FETCH when mem_ready.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALUWB.
  - ALUWB: reg_dst=1, reg_write=1. Then FETCH.
  - BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1. Then FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10. Then ADDIWB.
  - ADDIWB: reg_write=1 (reg_dst=0, mem_to_reg=0). Then FETCH.
  - JUMP: pc_src=10, pc_write=1. Then FETCH.

## Timing
- Reset:
  - `reset` high at an edge forces `state` to FETCH next cycle, regardless of current state or a stall.
  - While reset is asserted, outputs follow FETCH decode with ir_write=pc_write=0, and illegal_op=0.
  - Reset mid-instruction abandons the instruction; no further write enables issue for it.
- Cycles per instruction with mem_ready constantly 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each stall cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Write enables are single-cycle pulses, except mem_write, which is level for the duration of MEMWR.
- `pc_en` in BRANCH is high only if `zero` is high in that same cycle.
- `illegal_op` is high only in the DECODE cycle that sees an unsupported opcode; the next cycle is FETCH.
- Zero-wait back-to-back instructions: the cycle after any final state is FETCH.

## Test plan
- Reset, then `op`=000000, mem_ready=1:
  - state sequence 0,1,6,7,0;
  - alu_op=10 only in state 6;
  - reg_write=1, reg_dst=1 only in state 7.
- lw (100011) with mem_ready low for 2 cycles in MEMRD:
  - sequence 0,1,2,3,3,3,4,0;
  - i_or_d=1 for all three MEMRD cycles;
  - mem_to_reg=reg_write=1 in state 4.
- sw (101011) with mem_ready=0 for 1 cycle in MEMWR:
  - mem_write high for exactly 2 cycles;
  - reg_write never asserted.
- beq (000100):
  - with zero=1 in BRANCH: pc_en=1, pc_src=01, alu_op=01;
  - repeat with zero=0: pc_en=0.
- j (000010) then addi (001000):
  - j: sequence 0,1,11 with pc_write=1, pc_src=10;
  - addi: sequence 0,1,9,10,0 with alu_src_b=10 in state 9.
- Illegal and reset cases:
  - `op`=111111 → illegal_op pulses once in DECODE, next state 0, no write enables;
  - reset asserted in EXECUTE → next state 0 and ALUWB never entered.
